// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
// Pure declarations: no latency and no flow control of its own.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Bit-counter width; never below one bit so WIDTH=1 still has a counter.
    function automatic int cnt_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two inputs.
// Combinational, zero latency, no flow control.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/serial_fa_bit.sv
// Full-adder bit cell from two half adders and an OR on their carries.
// Combinational, zero latency, no flow control.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;
    logic g0;
    logic g1;

    half_adder u_ha0 (.x(a), .y(b),  .s(p), .c(g0));
    half_adder u_ha1 (.x(p), .y(ci), .s(s), .c(g1));

    assign co = g0 | g1;
endmodule

// File: rtl/serial_add_sched.sv
// Bit-serial adder: one shared full-adder cell stepped LSB-first, WIDTH cycles accept-to-done.
// No backpressure: start is taken only in IDLE/DONE and silently ignored while busy.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last;

    serial_fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_c)
    );

    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
    assign s_next = (s_sh >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            cnt   <= '0;
            carry <= cin;
        end else if (state_q == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_next;
            carry <= bit_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= s_next;
                cout <= bit_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sched.sv
// Bench for serial_add_sched at WIDTH=8 and WIDTH=1 against an arithmetic a+b+cin model.
module tb_serial_add_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_sched #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_sched #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on the first negedge after the accepting edge; returns cycles until done.
    task automatic wait_done8(input int poke, input logic [7:0] pa, input logic [7:0] pb,
                              output int lat, output int busyc);
        lat   = 0;
        busyc = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busyc++;
            if (poke > 0) begin
                start8 = (lat == poke);
                a8 = pa;
                b8 = pb;
                cin8 = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                       input int poke, input string tag);
        logic [8:0] exp;
        int lat, busyc;
        exp = 9'(ta) + 9'(tb_) + 9'(tc);
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb_; cin8 = tc;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        wait_done8(poke, ~ta, 8'h77, lat, busyc);
        check({tag, "_sum"},  64'(sum8),  64'(exp[7:0]));
        check({tag, "_cout"}, 64'(cout8), 64'(exp[8]));
        check({tag, "_lat"},  64'(lat),   64'd8);
        check({tag, "_busy_cycles"}, 64'(busyc), 64'd8);
        check({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done8), 64'd0);
    endtask

    task automatic op1(input logic ta, input logic tb_, input logic tc, input string tag);
        logic [1:0] exp;
        int lat;
        exp = 2'(ta) + 2'(tb_) + 2'(tc);
        @(negedge clk);
        start1 = 1'b1; a1 = ta; b1 = tb_; cin1 = tc;
        @(negedge clk);
        start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
        lat = 0;
        while (done1 !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_sum"},  64'(sum1),  64'(exp[0]));
        check({tag, "_cout"}, 64'(cout1), 64'(exp[1]));
        check({tag, "_lat"},  64'(lat),   64'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done1), 64'd0);
    endtask

    initial begin
        int lat, busyc, ndone;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy8), 64'd0);
        check("rst_done", 64'(done8), 64'd0);
        check("rst_sum",  64'(sum8),  64'd0);
        check("rst_cout", 64'(cout8), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        rst = 1'b0;

        op8(8'h5A, 8'h3C, 1'b0, 0, "basic");
        op8(8'hFF, 8'h01, 1'b0, 0, "wrap");
        op8(8'hFF, 8'h00, 1'b1, 0, "cin_wrap");
        op8(8'h00, 8'h00, 1'b1, 0, "cin_only");
        op8(8'h12, 8'h34, 1'b0, 3, "ignored_start");

        // Abort mid-run: partial result discarded, outputs cleared, no done.
        op8(8'h00, 8'h00, 1'b1, 0, "pre_abort");
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_sum",  64'(sum8),  64'd0);
        check("abort_cout", 64'(cout8), 64'd0);
        rst = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        op8(8'hA5, 8'h5A, 1'b1, 0, "after_abort");

        // Back-to-back: start held through DONE.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20;
        wait_done8(0, 8'h00, 8'h00, lat, busyc);
        check("b2b_first_lat", 64'(lat), 64'd8);
        check("b2b_first_sum", 64'(sum8), 64'h03);
        start8 = 1'b1;
        @(negedge clk);
        check("b2b_busy_rise", 64'(busy8), 64'd1);
        check("b2b_done_fall", 64'(done8), 64'd0);
        start8 = 1'b0;
        wait_done8(0, 8'h00, 8'h00, lat, busyc);
        check("b2b_second_lat",  64'(lat),   64'd8);
        check("b2b_second_sum",  64'(sum8),  64'h30);
        check("b2b_second_cout", 64'(cout8), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand");
        end

        op1(1'b1, 1'b1, 1'b1, "w1_max");
        for (int i = 0; i < 20; i++) begin
            op1(1'($urandom), 1'($urandom), 1'($urandom), "w1_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
